// File: rtl/array_mac_pkg.sv
// Shared types and width helpers for the array_mac_pipelined MAC primitive.
//   mac_mode_e : per-transaction operand interpretation (unsigned / signed)
//   mac_side_t : sideband bits that travel with each product down the pipe
//   mac_prod_w : full-precision product width for a given operand width
package array_mac_pkg;

  typedef enum logic {
    MAC_UNSIGNED = 1'b0,
    MAC_SIGNED   = 1'b1
  } mac_mode_e;

  typedef struct packed {
    mac_mode_e mode;
    logic      acc_en;
    logic      acc_clr;
  } mac_side_t;

  localparam int MAC_MIN_DATAWIDTH = 2;
  localparam int MAC_MIN_STAGES    = 1;

  // A DATAWIDTH x DATAWIDTH product is exact in 2*DATAWIDTH bits in both modes.
  function automatic int mac_prod_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/array_mac_stage.sv
// One retimable pipeline register of the MAC: valid bit, product and sideband.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (clears valid, product, sideband)
//   i_en     - load enable; low holds the stage (downstream stall)
//   i_valid  - upstream valid
//   i_prod   - upstream product
//   i_side   - upstream sideband (mode, acc_en, acc_clr)
//   o_valid  - registered valid
//   o_prod   - registered product
//   o_side   - registered sideband
module array_mac_stage
  import array_mac_pkg::*;
#(
  parameter int PROD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [PROD_W-1:0] i_prod,
  input  mac_side_t         i_side,
  output logic              o_valid,
  output logic [PROD_W-1:0] o_prod,
  output mac_side_t         o_side
);

  logic              r_vld_p;
  logic [PROD_W-1:0] r_prod_p;
  mac_side_t         r_side_p;

  // Product is cleared too so the block output reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p  <= 1'b0;
      r_prod_p <= '0;
      r_side_p <= '0;
    end else if (i_en) begin
      r_vld_p  <= i_valid;
      r_prod_p <= i_prod;
      r_side_p <= i_side;
    end
  end

  assign o_valid = r_vld_p;
  assign o_prod  = r_prod_p;
  assign o_side  = r_side_p;

endmodule

// File: rtl/array_mac_pipelined.sv
// Pipelined signed/unsigned multiplier with optional wrap-around accumulator.
// The product is formed combinationally, then carried through
// NUM_PIPELINE_STAGES register stages under a valid/ready handshake.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   i_valid    - input transaction present
//   i_ready    - block can accept this cycle (low only while output stalled)
//   A, B       - DATAWIDTH operands
//   i_signed   - 1 = two's-complement operands, 0 = unsigned
//   i_acc_en   - add this product into the accumulator
//   i_acc_clr  - load accumulator with this product, clear overflow
//   o_valid    - output transaction present
//   o_ready    - downstream accepts
//   Z_final    - 2*DATAWIDTH exact product
//   acc_out    - ACC_WIDTH accumulator (updated one cycle after output handshake)
//   acc_ovf    - sticky accumulator overflow
module array_mac_pipelined
  import array_mac_pkg::*;
#(
  parameter int DATAWIDTH           = 8,
  parameter int NUM_PIPELINE_STAGES = 2,
  parameter int ACC_WIDTH           = 2 * DATAWIDTH + 4,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [DATAWIDTH-1:0]   A,
  input  logic [DATAWIDTH-1:0]   B,
  input  logic                   i_signed,
  input  logic                   i_acc_en,
  input  logic                   i_acc_clr,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [2*DATAWIDTH-1:0] Z_final,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_ovf
);

  localparam int PW = mac_prod_w(DATAWIDTH);
  localparam int NS = NUM_PIPELINE_STAGES;

  if (NUM_PIPELINE_STAGES < MAC_MIN_STAGES) begin : g_bad_stages
    $error("array_mac_pipelined[%0d]: NUM_PIPELINE_STAGES must be at least 1", INSTANCE_ID);
  end
  if (DATAWIDTH < MAC_MIN_DATAWIDTH) begin : g_bad_width
    $error("array_mac_pipelined[%0d]: DATAWIDTH must be at least 2", INSTANCE_ID);
  end
  if (ACC_WIDTH < PW) begin : g_bad_acc
    $error("array_mac_pipelined[%0d]: ACC_WIDTH must be at least 2*DATAWIDTH", INSTANCE_ID);
  end

  // Extend a product to accumulator width according to its transaction mode.
  function automatic logic [ACC_WIDTH-1:0] acc_extend(input logic [PW-1:0] p,
                                                       input mac_mode_e     m);
    if (m == MAC_SIGNED) return ACC_WIDTH'($signed(p));
    else                 return ACC_WIDTH'(p);
  endfunction

  // Overflow of a + b: carry-out for unsigned, sign overflow for signed.
  function automatic logic acc_add_ovf(input logic [ACC_WIDTH-1:0] a,
                                       input logic [ACC_WIDTH-1:0] b,
                                       input mac_mode_e            m);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (m == MAC_SIGNED)
      return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    else
      return s[ACC_WIDTH];
  endfunction

  logic                w_stall;
  logic [PW-1:0]       w_a_ext;
  logic [PW-1:0]       w_b_ext;
  logic [PW-1:0]       w_prod;
  mac_side_t           w_side_in;

  logic                w_vld_p  [0:NS];
  logic [PW-1:0]       w_prod_p [0:NS];
  mac_side_t           w_side_p [0:NS];

  // Operands are widened to the product width first; the low PW bits of the
  // PW x PW product are then the exact product in either mode.
  always_comb begin
    if (i_signed) begin
      w_a_ext = PW'($signed(A));
      w_b_ext = PW'($signed(B));
    end else begin
      w_a_ext = PW'(A);
      w_b_ext = PW'(B);
    end
    w_prod            = w_a_ext * w_b_ext;
    w_side_in.mode    = i_signed ? MAC_SIGNED : MAC_UNSIGNED;
    w_side_in.acc_en  = i_acc_en;
    w_side_in.acc_clr = i_acc_clr;
  end

  // Whole pipe freezes on output stall; bubbles are not collapsed.
  assign w_stall = w_vld_p[NS] && !o_ready;
  assign i_ready = !w_stall;

  assign w_vld_p[0]  = i_valid;
  assign w_prod_p[0] = w_prod;
  assign w_side_p[0] = w_side_in;

  // ---- register stages 1..NUM_PIPELINE_STAGES ----
  for (genvar g = 0; g < NS; g++) begin : g_stage
    array_mac_stage #(
      .PROD_W (PW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst),
      .i_en    (!w_stall),
      .i_valid (w_vld_p[g]),
      .i_prod  (w_prod_p[g]),
      .i_side  (w_side_p[g]),
      .o_valid (w_vld_p[g+1]),
      .o_prod  (w_prod_p[g+1]),
      .o_side  (w_side_p[g+1])
    );
  end

  assign o_valid = w_vld_p[NS];
  assign Z_final = w_prod_p[NS];

  logic                 w_fire;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic                 w_ovf_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;

  assign w_fire = w_vld_p[NS] && o_ready;

  always_comb begin
    w_prod_ext = acc_extend(w_prod_p[NS], w_side_p[NS].mode);
    w_acc_nxt  = r_acc;
    w_ovf_nxt  = r_ovf;
    if (w_side_p[NS].acc_clr) begin
      w_acc_nxt = w_prod_ext;
      w_ovf_nxt = 1'b0;
    end else if (w_side_p[NS].acc_en) begin
      w_acc_nxt = r_acc + w_prod_ext;
      w_ovf_nxt = r_ovf | acc_add_ovf(r_acc, w_prod_ext, w_side_p[NS].mode);
    end
  end

  // ---- accumulator stage (after output handshake) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_fire) begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign acc_out = r_acc;
  assign acc_ovf = r_ovf;

endmodule

// File: tb/tb_array_mac_pipelined.sv
module tb_array_mac_pipelined;

  localparam int DW  = 4;
  localparam int NS  = 2;
  localparam int AW  = 12;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          i_signed;
  logic          i_acc_en;
  logic          i_acc_clr;
  logic          o_valid;
  logic          o_ready;
  logic [2*DW-1:0] Z_final;
  logic [AW-1:0] acc_out;
  logic          acc_ovf;

  array_mac_pipelined #(
    .DATAWIDTH           (DW),
    .NUM_PIPELINE_STAGES (NS),
    .ACC_WIDTH           (AW),
    .INSTANCE_ID         (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .A         (A),
    .B         (B),
    .i_signed  (i_signed),
    .i_acc_en  (i_acc_en),
    .i_acc_clr (i_acc_clr),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .Z_final   (Z_final),
    .acc_out   (acc_out),
    .acc_ovf   (acc_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  z;
    bit          cacc;
    logic [11:0] acc;
    logic        ovf;
    bit          clat;
    int          acyc;
  } exp_t;

  exp_t q[$];
  exp_t pend_e;
  bit   acc_pend = 0;
  int   vld_cnt  = 0;
  int   checks   = 0;
  int   errors   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Issue one transaction and queue its hand-computed expected response.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic sg,
                      input logic en, input logic clr, input logic [7:0] ez,
                      input bit cacc, input logic [11:0] eacc, input logic eovf,
                      input bit clat);
    int   n;
    exp_t e;
    A = a; B = b; i_signed = sg; i_acc_en = en; i_acc_clr = clr;
    i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!i_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!i_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got i_ready 0 expected 1 within 50 cycles");
    end else begin
      e.z = ez; e.cacc = cacc; e.acc = eacc; e.ovf = eovf; e.clat = clat;
      e.acyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (acc_pend) begin
        chk("acc_out", 32'(acc_out), 32'(pend_e.acc));
        chk("acc_ovf", 32'(acc_ovf), 32'(pend_e.ovf));
        acc_pend = 0;
      end
      if (rst && o_valid) begin
        vld_cnt++;
        if (o_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got Z_final 0x%0h expected no output", Z_final);
          end else begin
            e = q.pop_front();
            chk("Z_final", 32'(Z_final), 32'(e.z));
            if (e.clat) chk("latency", 32'(cyc + 1 - e.acyc), 32'(NS));
            if (e.cacc) begin
              pend_e   = e;
              acc_pend = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    int v;
    rst = 1'b0; i_valid = 1'b0; A = '0; B = '0;
    i_signed = 1'b0; i_acc_en = 1'b0; i_acc_clr = 1'b0; o_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_Z_final", 32'(Z_final), 32'd0);
    chk("rst_acc_out", 32'(acc_out), 32'd0);
    chk("rst_acc_ovf", 32'(acc_ovf), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1. Unsigned basic
    vld_cnt = 0;
    send(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 8'hE1, 0, 12'h0, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_valid_one_cycle", 32'(vld_cnt), 32'd1);
    send(4'd15, 4'd9,  1'b0, 1'b0, 1'b0, 8'h87, 0, 12'h0, 1'b0, 1);
    send(4'd10, 4'd15, 1'b0, 1'b0, 1'b0, 8'h96, 0, 12'h0, 1'b0, 1);

    // 2. Signed vs unsigned on identical bits
    send(4'b1111, 4'b1001, 1'b1, 1'b0, 1'b0, 8'h07, 0, 12'h0, 1'b0, 1);
    send(4'b0111, 4'b1000, 1'b1, 1'b0, 1'b0, 8'hC8, 0, 12'h0, 1'b0, 1);
    send(4'b1111, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h87, 0, 12'h0, 1'b0, 1);
    send(4'b0111, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h38, 0, 12'h0, 1'b0, 1);
    drain();

    // 3. Backpressure: second product (5*6=0x1E) is held at the output
    fork
      begin
        send(4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 8'h0C, 0, 12'h0, 1'b0, 0);
        send(4'd5, 4'd6, 1'b0, 1'b0, 1'b0, 8'h1E, 0, 12'h0, 1'b0, 0);
        send(4'd7, 4'd7, 1'b0, 1'b0, 1'b0, 8'h31, 0, 12'h0, 1'b0, 0);
        send(4'd2, 4'd9, 1'b0, 1'b0, 1'b0, 8'h12, 0, 12'h0, 1'b0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t3_i_ready_stall", 32'(i_ready), 32'd0);
          chk("t3_o_valid_hold", 32'(o_valid), 32'd1);
          chk("t3_Z_hold", 32'(Z_final), 32'h1E);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
    drain();

    // 4. Accumulate
    send(4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 8'h0F, 1, 12'd15, 1'b0, 1);
    send(4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 8'h04, 1, 12'd19, 1'b0, 1);
    send(4'd1, 4'd7, 1'b0, 1'b1, 1'b0, 8'h07, 1, 12'd26, 1'b0, 1);
    send(4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 8'h06, 1, 12'd26, 1'b0, 1);

    // 5. Unsigned overflow: 225*19 = 4275 -> 179, carry on last add only
    send(4'd15, 4'd15, 1'b0, 1'b0, 1'b1, 8'hE1, 1, 12'd225, 1'b0, 1);
    for (int k = 0; k < 18; k++) begin
      v = 225 * (k + 2);
      send(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 8'hE1, 1, 12'(v % 4096), (v > 4095), 1);
    end
    send(4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 8'h01, 1, 12'd1, 1'b0, 1);

    // Mixed modes: signed -56 sign-extends, unsigned add reports carry
    send(4'b0111, 4'b1000, 1'b1, 1'b0, 1'b1, 8'hC8, 1, 12'hFC8, 1'b0, 1);
    send(4'd15,   4'd15,   1'b0, 1'b1, 1'b0, 8'hE1, 1, 12'h0A9, 1'b1, 1);
    send(4'b1111, 4'b1001, 1'b1, 1'b0, 1'b1, 8'h07, 1, 12'h007, 1'b0, 1);
    send(4'b0111, 4'b1000, 1'b1, 1'b1, 1'b0, 8'hC8, 1, 12'hFCF, 1'b0, 1);
    // carry out but no signed overflow
    send(4'b0111, 4'b1000, 1'b1, 1'b1, 1'b0, 8'hC8, 1, 12'hF97, 1'b0, 1);

    // Signed overflow: 64*32 = 2048 crosses +2047
    send(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 8'h40, 1, 12'h040, 1'b0, 1);
    for (int k = 0; k < 31; k++) begin
      v = 64 * (k + 2);
      send(4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0, 8'h40, 1, 12'(v), (v > 2047), 1);
    end
    drain();
    chk("t5_ovf_before_reset", 32'(acc_ovf), 32'd1);

    // 6. Reset with two transactions in flight
    send(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 8'h02, 0, 12'h0, 1'b0, 0);
    send(4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 8'h06, 0, 12'h0, 1'b0, 0);
    #2;
    rst = 1'b0;
    q.delete();
    acc_pend = 0;
    #1;
    chk("t6_async_o_valid", 32'(o_valid), 32'd0);
    chk("t6_async_Z_final", 32'(Z_final), 32'd0);
    chk("t6_async_acc_out", 32'(acc_out), 32'd0);
    chk("t6_async_acc_ovf", 32'(acc_ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_stale", 32'(o_valid), 32'd0);
      chk("t6_i_ready", 32'(i_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    send(4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 8'h09, 0, 12'h0, 1'b0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/array_mac_pipelined.md
Name: array_mac_pipelined

Overview:
- Parametrised successor to the team's array multiplier.
- Multiplies two DATAWIDTH operands with a per-transaction signed/unsigned mode.
- Carries transactions through NUM_PIPELINE_STAGES retimable register stages under a valid/ready handshake with backpressure.
- Optionally folds each product into a wrap-around accumulator with a sticky overflow flag.
- Used as the MAC primitive for retiming experiments and downstream datapaths.

Parameters:
- DATAWIDTH, 8: operand width, at least 2.
- NUM_PIPELINE_STAGES, 2: register stages from accept to output, at least 1. A value of 0 is an elaboration error.
- ACC_WIDTH, 2*DATAWIDTH+4: accumulator width, at least 2*DATAWIDTH.
- INSTANCE_ID, 0: identifier for debug and simulation messages only. No functional effect.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  input transaction present.
- i_ready  out  1  block can accept this cycle.
- A  in  DATAWIDTH  multiplicand.
- B  in  DATAWIDTH  multiplier.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- i_acc_en  in  1  add this product into the accumulator.
- i_acc_clr  in  1  load the accumulator with this product and clear the overflow flag.
- o_valid  out  1  output transaction present.
- o_ready  in  1  downstream accepts.
- Z_final  out  2*DATAWIDTH  product.
- acc_out  out  ACC_WIDTH  accumulator value.
- acc_ovf  out  1  sticky accumulator overflow.

Behaviour:
- Reset (rst low, asynchronous):
  - All stage valid bits, o_valid, Z_final, acc_out and acc_ovf go to 0.
  - i_ready is 1 from the first edge after release.
  - In-flight transactions are discarded; nothing stale appears after release.
- Accept: a transaction is accepted when i_valid && i_ready. A, B, i_signed, i_acc_en and i_acc_clr are captured together as one transaction.
- Stall:
  - stall = o_valid && !o_ready, and i_ready = !stall.
  - On stall every stage holds its value; nothing is lost, duplicated or reordered.
  - No bubble collapse is required.
- Latency:
  - Exactly NUM_PIPELINE_STAGES cycles from accept to o_valid when not stalled.
  - Full throughput is one transaction per cycle.
- Arithmetic:
  - Signed mode: full 2*DATAWIDTH two's-complement product. Unsigned mode: zero-extended product.
  - The product is exact; it cannot overflow Z_final.
- Pipeline structure: the product is formed combinationally, followed by NUM_PIPELINE_STAGES register stages. Each stage carries the product, the sideband bits and a valid bit, so that retiming can redistribute logic. Latency must not depend on where logic lands.
- Output hold: Z_final and o_valid stay stable while stalled.
- Accumulator, evaluated at the output handshake (o_valid && o_ready):
  - Extend the product to ACC_WIDTH, sign-extended if the transaction was signed, zero-extended otherwise.
  - If acc_clr: acc_out <= extended product, acc_ovf <= 0. acc_clr has priority over acc_en.
  - Else if acc_en: acc_out <= acc_out + extended product, wrapping modulo 2^ACC_WIDTH.
    - acc_ovf is set if the add overflows: unsigned carry-out in unsigned mode, signed overflow in signed mode.
    - acc_ovf stays set until the next acc_clr.
  - Else: acc_out and acc_ovf are unchanged.
  - acc_out is registered, so it reflects the transaction one cycle after its handshake.
- Mixed modes: mixing signed and unsigned transactions within one accumulation is legal. Each add uses its own transaction's mode.

Decomposition:
- Package array_mac_pkg:
  - enum mac_mode_e {MAC_UNSIGNED, MAC_SIGNED}.
  - struct mac_side_t {mode, acc_en, acc_clr}.
  - Width helper constants.
- One sub-module, array_mac_stage: a single pipeline register holding valid, product and side, with an enable (!stall) and asynchronous active-low reset. Instantiated NUM_PIPELINE_STAGES times in a generate loop.
- The accumulator and overflow logic stay in the top level.

Test Plan (DATAWIDTH=4, NUM_PIPELINE_STAGES=2, ACC_WIDTH=12):
1. Unsigned basic: A=15, B=15 → Z_final=225 (8'hE1), o_valid high for exactly one cycle, 2 cycles after accept. Follow with A=15, B=9 → 135 and A=10, B=15 → 150, back-to-back.
2. Signed mode:
   - A=4'b1111, B=4'b1001 → 8'h07 (-1×-7).
   - A=4'b0111, B=4'b1000 → 8'hC8 (-56).
   - The same operand bits in unsigned mode → 135 and 56.
3. Backpressure: stream 4 transactions and drop o_ready for 3 cycles mid-stream → i_ready low during the stall, Z_final held, all 4 products delivered in order, no duplicates.
4. Accumulate:
   - clr with 3×5 → acc_out=15.
   - acc_en with 2×2 → 19.
   - acc_en with 1×7 → 26.
   - Transaction with neither acc_en nor acc_clr → acc_out stays 26.
5. Overflow: clr with 15×15, then 18 acc_en transactions of 15×15 → acc_out=179 (4275 mod 4096), acc_ovf=1. A subsequent clr with 1×1 → acc_out=1, acc_ovf=0.
6. Reset mid-flight: assert rst with 2 transactions in flight → o_valid, acc_out and acc_ovf go to 0 asynchronously. After release there is no output until new input is accepted; first new result appears 2 cycles after its accept.
